// File: rtl/bus_arbiter_if.sv
// Shared bus bundle between the requesting masters, the arbiter and the memory/peripheral slaves.
// The master modport is the arbiter's view: it drives grants and the slave-side bus.
interface bus_arbiter_if #(
  parameter int N_REQ = 3
);
  logic [N_REQ-1:0]    req;
  logic [N_REQ-1:0]    req_rd;
  logic [16*N_REQ-1:0] req_addr;
  logic [16*N_REQ-1:0] req_wdata;
  logic [N_REQ-1:0]    gnt;
  logic [N_REQ-1:0]    done;
  logic                err;
  logic [15:0]         rdata;
  logic                ready_ram, ready_rom, ready_ext_mem, ready_gpr;
  logic [15:0]         mem_rdata;
  logic                read;
  logic                cs_ram, cs_rom, cs_ext_mem, cs_gpr;
  logic [15:0]         address;
  logic [15:0]         mem_wdata;

  modport master (
    input  req, req_rd, req_addr, req_wdata,
    input  ready_ram, ready_rom, ready_ext_mem, ready_gpr, mem_rdata,
    output gnt, done, err, rdata,
    output read, cs_ram, cs_rom, cs_ext_mem, cs_gpr, address, mem_wdata
  );

  modport slave (
    output req, req_rd, req_addr, req_wdata,
    output ready_ram, ready_rom, ready_ext_mem, ready_gpr, mem_rdata,
    input  gnt, done, err, rdata,
    input  read, cs_ram, cs_rom, cs_ext_mem, cs_gpr, address, mem_wdata
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared 16-bit memory/peripheral bus: address decode to slave
// selects, ready handshake and timeout abort. Three-state FSM, all outputs registered.
module bus_arbiter #(
  parameter int          N_REQ    = 3,
  parameter int          TIMEOUT  = 15,
  parameter logic [15:0] ROM_LAST = 16'h3FFF,
  parameter logic [15:0] RAM_LAST = 16'hBFFF,
  parameter logic [15:0] GPR_BASE = 16'hFF00
) (
  input  logic              clk,
  input  logic              reset,
  bus_arbiter_if.master     bus
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t           r_state;
  logic [PW-1:0]    r_ptr, r_win;
  logic [7:0]       r_timer;
  logic [N_REQ-1:0] r_gnt, r_done;
  logic             r_err, r_read;
  logic [3:0]       r_cs;  // {gpr, ext, ram, rom}
  logic [15:0]      r_addr, r_wdata, r_rdata;

  logic [PW-1:0]    w_win;
  logic             w_any, w_rdy;
  logic [15:0]      w_addr, w_wdata;

  function automatic logic [3:0] decode(input logic [15:0] a);
    if (a <= ROM_LAST)      return 4'b0001;
    else if (a <= RAM_LAST) return 4'b0010;
    else if (a >= GPR_BASE) return 4'b1000;
    else                    return 4'b0100;
  endfunction

  // Walk from the highest offset down so the requester closest to r_ptr wins.
  always_comb begin
    w_win = '0;
    w_any = |bus.req;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (bus.req[(int'(r_ptr) + k) % N_REQ])
        w_win = PW'((int'(r_ptr) + k) % N_REQ);
    end
  end

  assign w_addr  = bus.req_addr[int'(w_win)*16 +: 16];
  assign w_wdata = bus.req_wdata[int'(w_win)*16 +: 16];
  assign w_rdy   = |(r_cs & {bus.ready_gpr, bus.ready_ext_mem, bus.ready_ram, bus.ready_rom});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_win   <= '0;
      r_timer <= '0;
      r_gnt   <= '0;
      r_done  <= '0;
      r_err   <= 1'b0;
      r_read  <= 1'b0;
      r_cs    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_win        <= w_win;
            r_gnt        <= '0;
            r_gnt[w_win] <= 1'b1;
            r_addr       <= w_addr;
            r_wdata      <= w_wdata;
            r_read       <= bus.req_rd[w_win];
            r_cs         <= decode(w_addr);
            r_timer      <= '0;
            r_state      <= ACCESS;
          end
        end
        ACCESS: begin
          if (w_rdy) begin
            if (r_read) r_rdata <= bus.mem_rdata;
            r_done[r_win] <= 1'b1;
            r_cs          <= '0;
            r_state       <= DONE;
          end else if (r_timer == 8'(TIMEOUT - 1)) begin
            if (r_read) r_rdata <= 16'hFFFF;
            r_done[r_win] <= 1'b1;
            r_err         <= 1'b1;
            r_cs          <= '0;
            r_state       <= DONE;
          end else begin
            r_timer <= r_timer + 8'd1;
          end
        end
        DONE: begin
          r_done  <= '0;
          r_err   <= 1'b0;
          r_gnt   <= '0;
          r_ptr   <= (r_win == PW'(N_REQ - 1)) ? '0 : r_win + PW'(1);
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.gnt        = r_gnt;
  assign bus.done       = r_done;
  assign bus.err        = r_err;
  assign bus.rdata      = r_rdata;
  assign bus.read       = r_read;
  assign bus.cs_rom     = r_cs[0];
  assign bus.cs_ram     = r_cs[1];
  assign bus.cs_ext_mem = r_cs[2];
  assign bus.cs_gpr     = r_cs[3];
  assign bus.address    = r_addr;
  assign bus.mem_wdata  = r_wdata;
endmodule
